// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM single-port RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } arb_state_e;

    // Grant identifiers used to select which requester's fields are latched.
    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch (IF) and load/store (MEM).
// Latency: grant at T, ram_en at T+1, valid/done pulse one cycle after ram_rdy (min 2 cycles).
// Backpressure: ram_* held until ram_rdy; requesters held via stall_IF/stall_MEM until their pulse.
//
// Ports:
//   if_req/if_addr/flush_IF  -> fetch request, squashed by flush_IF
//   if_rdata/if_valid        <- fetched instruction, one-cycle valid pulse
//   mem_req/we/addr/wdata    -> load/store request, fixed priority over IF
//   mem_rdata/mem_done       <- load data (unchanged on stores), one-cycle done pulse
//   stall_IF/stall_MEM       <- combinational hold requests to the pipeline
//   ram_en/we/addr/wdata     <- registered RAM command, ram_rdata/ram_rdy -> completion
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush_IF,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_IF,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall_MEM,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_rdy
);
    import mem_arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_done_q, mem_done_d;
    logic              squash_q, squash_d;

    logic mem_elig;
    logic if_elig;
    logic gnt_id;

    // A requester whose pulse is out this cycle still has its request high;
    // masking it here stops the same access from being granted twice. This
    // also lets IF win the cycle in which MEM's done pulses, so IF cannot starve.
    always_comb begin
        mem_elig = mem_req && !mem_done_q;
        if_elig  = if_req && !if_valid_q && !flush_IF;
        gnt_id   = mem_elig ? GNT_MEM : GNT_IF;
    end

    always_comb begin
        state_d     = state_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        squash_d    = squash_q;
        if_valid_d  = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_elig || if_elig) begin
                    ram_en_d = 1'b1;
                    if (gnt_id == GNT_MEM) begin
                        ram_we_d    = mem_we;
                        ram_addr_d  = mem_addr;
                        ram_wdata_d = mem_wdata;
                        state_d     = MEM_BUSY;
                    end else begin
                        ram_we_d   = 1'b0;
                        ram_addr_d = if_addr;
                        state_d    = IF_BUSY;
                    end
                end
            end
            IF_BUSY: begin
                if (ram_rdy) begin
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    squash_d = 1'b0;
                    state_d  = IDLE;
                    // A flush seen earlier or in this very cycle drops the fetch.
                    if (!(squash_q || flush_IF)) begin
                        if_rdata_d = ram_rdata;
                        if_valid_d = 1'b1;
                    end
                end else if (flush_IF) begin
                    squash_d = 1'b1;
                end
            end
            MEM_BUSY: begin
                if (ram_rdy) begin
                    ram_en_d   = 1'b0;
                    ram_we_d   = 1'b0;
                    mem_done_d = 1'b1;
                    state_d    = IDLE;
                    if (!ram_we_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
            squash_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
            squash_q    <= squash_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign stall_MEM = mem_req && !mem_done_q;
    assign stall_IF  = if_req && !if_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the shared RAM port.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          flush_IF;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          stall_IF;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          stall_MEM;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_rdy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .flush_IF(flush_IF),
        .if_rdata(if_rdata), .if_valid(if_valid), .stall_IF(stall_IF),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_MEM(stall_MEM),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_rdy(ram_rdy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse/write tallies observed on the DUT, used by directed tests.
    int n_ifv = 0;
    int n_md  = 0;
    int n_wr  = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_valid) n_ifv <= n_ifv + 1;
            if (mem_done) n_md  <= n_md + 1;
        end
    end
    always @(posedge clk) begin
        if (rst_n && ram_en && ram_we && ram_rdy) n_wr <= n_wr + 1;
    end

    // Transaction model: at most one outstanding RAM access, described by who
    // owns it and what it carries; completion produces a pulse the next cycle.
    logic          m_busy, m_owner_mem, m_we, m_squash;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_if_valid, m_mem_done;
    logic [DW-1:0] m_if_rdata, m_mem_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_owner_mem <= 1'b0; m_we <= 1'b0; m_squash <= 1'b0;
            m_addr <= '0; m_wdata <= '0;
            m_if_valid <= 1'b0; m_mem_done <= 1'b0;
            m_if_rdata <= '0; m_mem_rdata <= '0;
        end else begin
            m_if_valid <= 1'b0;
            m_mem_done <= 1'b0;
            if (m_busy) begin
                if (ram_rdy) begin
                    m_busy   <= 1'b0;
                    m_squash <= 1'b0;
                    if (m_owner_mem) begin
                        m_mem_done <= 1'b1;
                        if (!m_we) m_mem_rdata <= ram_rdata;
                    end else if (!(m_squash || flush_IF)) begin
                        m_if_valid <= 1'b1;
                        m_if_rdata <= ram_rdata;
                    end
                end else if (!m_owner_mem && flush_IF) begin
                    m_squash <= 1'b1;
                end
            end else if (mem_req && !m_mem_done) begin
                m_busy <= 1'b1; m_owner_mem <= 1'b1;
                m_we <= mem_we; m_addr <= mem_addr; m_wdata <= mem_wdata;
            end else if (if_req && !m_if_valid && !flush_IF) begin
                m_busy <= 1'b1; m_owner_mem <= 1'b0;
                m_we <= 1'b0; m_addr <= if_addr;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ram_en", ram_en, m_busy);
            if (m_busy) begin
                check("ram_addr", ram_addr, m_addr);
                check("ram_we", ram_we, m_we);
                if (m_we) check("ram_wdata", ram_wdata, m_wdata);
            end
            check("if_valid", if_valid, m_if_valid);
            check("if_rdata", if_rdata, m_if_rdata);
            check("mem_done", mem_done, m_mem_done);
            check("mem_rdata", mem_rdata, m_mem_rdata);
            check("stall_IF", stall_IF, if_req && !m_if_valid);
            check("stall_MEM", stall_MEM, mem_req && !m_mem_done);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int ifv0, md0, wr0;
    logic if_rel, mem_rel;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; flush_IF = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        ram_rdata = '0; ram_rdy = 1'b0;
        tick(2);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_mem_done", mem_done, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        rst_n = 1'b1;
        tick(1);

        // Reset in the middle of a load.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10;
        tick(1);
        check("t1_ram_en", ram_en, 1);
        check("t1_ram_addr", ram_addr, 32'h10);
        rst_n = 1'b0;
        #1;
        check("t1_rst_ram_en", ram_en, 0);
        mem_req = 1'b0;
        tick(1);
        rst_n = 1'b1;
        md0 = n_md;
        tick(4);
        check("t1_no_done", n_md, md0);
        check("t1_idle", ram_en, 0);

        // Single fetch, one-cycle RAM.
        ifv0 = n_ifv;
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("t2_stall_T", stall_IF, 1);
        tick(1);
        check("t2_ram_en", ram_en, 1);
        check("t2_ram_addr", ram_addr, 32'h100);
        check("t2_ram_we", ram_we, 0);
        check("t2_stall_T1", stall_IF, 1);
        ram_rdy = 1'b1; ram_rdata = 32'h8C220004;
        tick(1);
        ram_rdy = 1'b0;
        check("t2_if_valid", if_valid, 1);
        check("t2_if_rdata", if_rdata, 32'h8C220004);
        check("t2_stall_T2", stall_IF, 0);
        tick(1);
        if_req = 1'b0;
        check("t2_pulse_end", if_valid, 0);
        check("t2_no_regrant", ram_en, 0);
        check("t2_pulse_cnt", n_ifv - ifv0, 1);

        // Simultaneous IF and MEM: store goes first, fetch in the done cycle.
        wr0 = n_wr; md0 = n_md; ifv0 = n_ifv;
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
        tick(1);
        check("t3_ram_we", ram_we, 1);
        check("t3_ram_addr", ram_addr, 32'h20);
        check("t3_ram_wdata", ram_wdata, 32'hDEADBEEF);
        ram_rdy = 1'b1;
        tick(1);
        ram_rdy = 1'b0;
        check("t3_mem_done", mem_done, 1);
        check("t3_store_rdata", mem_rdata, 0);
        tick(1);
        mem_req = 1'b0;
        check("t3_if_grant", ram_en, 1);
        check("t3_if_addr", ram_addr, 32'h104);
        check("t3_if_we", ram_we, 0);
        ram_rdy = 1'b1; ram_rdata = 32'hCAFE0001;
        tick(1);
        ram_rdy = 1'b0;
        check("t3_if_valid", if_valid, 1);
        check("t3_if_rdata", if_rdata, 32'hCAFE0001);
        tick(1);
        if_req = 1'b0;
        tick(1);
        check("t3_writes", n_wr - wr0, 1);
        check("t3_dones", n_md - md0, 1);
        check("t3_valids", n_ifv - ifv0, 1);

        // Variable-latency load.
        md0 = n_md;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
        #1;
        check("t4_stall_T", stall_MEM, 1);
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("t4_hold_en", ram_en, 1);
            check("t4_hold_addr", ram_addr, 32'h40);
            check("t4_hold_we", ram_we, 0);
            check("t4_stall", stall_MEM, 1);
        end
        ram_rdy = 1'b1; ram_rdata = 32'h1234;
        tick(1);
        ram_rdy = 1'b0;
        check("t4_mem_done", mem_done, 1);
        check("t4_mem_rdata", mem_rdata, 32'h1234);
        check("t4_stall_done", stall_MEM, 0);
        tick(1);
        mem_req = 1'b0;
        check("t4_dones", n_md - md0, 1);

        // Flush while the fetch is in flight.
        ifv0 = n_ifv;
        if_req = 1'b1; if_addr = 32'h200;
        tick(1);
        check("t5_addr", ram_addr, 32'h200);
        flush_IF = 1'b1;
        tick(1);
        flush_IF = 1'b0;
        tick(1);
        ram_rdy = 1'b1; ram_rdata = 32'hBAD00BAD;
        tick(1);
        ram_rdy = 1'b0;
        check("t5_squashed", if_valid, 0);
        check("t5_rdata_kept", if_rdata, 32'hCAFE0001);
        if_addr = 32'h300;
        tick(1);
        check("t5_refetch_en", ram_en, 1);
        check("t5_refetch_addr", ram_addr, 32'h300);
        ram_rdy = 1'b1; ram_rdata = 32'h300D0001;
        tick(1);
        ram_rdy = 1'b0;
        check("t5_refetch_valid", if_valid, 1);
        check("t5_refetch_rdata", if_rdata, 32'h300D0001);
        tick(1);
        if_req = 1'b0;
        check("t5_valids", n_ifv - ifv0, 1);

        // Flush coincident with ram_rdy.
        ifv0 = n_ifv;
        if_req = 1'b1; if_addr = 32'h400;
        tick(1);
        check("t5b_addr", ram_addr, 32'h400);
        ram_rdy = 1'b1; flush_IF = 1'b1; ram_rdata = 32'hDEAD0400;
        tick(1);
        ram_rdy = 1'b0; flush_IF = 1'b0; if_req = 1'b0;
        check("t5b_squashed", if_valid, 0);
        check("t5b_rdata_kept", if_rdata, 32'h300D0001);
        tick(1);
        check("t5b_idle", ram_en, 0);
        check("t5b_valids", n_ifv, ifv0);

        // Request held through its done cycle, then a new store.
        wr0 = n_wr; md0 = n_md;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h50; mem_wdata = 32'hA5A5A5A5;
        tick(1);
        check("t6_en1", ram_en, 1);
        ram_rdy = 1'b1;
        tick(1);
        ram_rdy = 1'b0;
        check("t6_done1", mem_done, 1);
        tick(1);
        check("t6_no_regrant", ram_en, 0);
        mem_addr = 32'h54; mem_wdata = 32'h5A5A5A5A;
        tick(1);
        check("t6_en2", ram_en, 1);
        check("t6_addr2", ram_addr, 32'h54);
        check("t6_wdata2", ram_wdata, 32'h5A5A5A5A);
        ram_rdy = 1'b1;
        tick(1);
        ram_rdy = 1'b0;
        check("t6_done2", mem_done, 1);
        tick(1);
        mem_req = 1'b0;
        tick(1);
        check("t6_writes", n_wr - wr0, 2);
        check("t6_dones", n_md - md0, 2);

        // Randomized traffic; the per-cycle compare process does the checking.
        if_rel = 1'b0; mem_rel = 1'b0;
        ifv0 = n_ifv; md0 = n_md;
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            if (($urandom % 500) == 0) begin
                rst_n = 1'b0;
                if_req = 1'b0; mem_req = 1'b0; flush_IF = 1'b0; ram_rdy = 1'b0;
                if_rel = 1'b0; mem_rel = 1'b0;
                #1;
                rst_n = 1'b1;
                continue;
            end
            flush_IF = 1'b0;
            if (if_rel) begin
                if_rel  = 1'b0;
                if_req  = ($urandom % 2) == 0;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end else if (if_valid) begin
                if_rel = 1'b1;
            end else if (!if_req && ($urandom % 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (($urandom % 12) == 0) begin
                flush_IF = 1'b1;
                if_rel   = 1'b0;
                if_req   = 1'b1;
                if_addr  = $urandom & 32'hFFFF_FFFC;
            end
            if (mem_rel) begin
                mem_rel   = 1'b0;
                mem_req   = ($urandom % 2) == 0;
                mem_we    = ($urandom % 2) == 0;
                mem_addr  = $urandom & 32'hFFFF_FFFC;
                mem_wdata = $urandom;
            end else if (mem_done) begin
                mem_rel = 1'b1;
            end else if (!mem_req && ($urandom % 3) == 0) begin
                mem_req   = 1'b1;
                mem_we    = ($urandom % 2) == 0;
                mem_addr  = $urandom & 32'hFFFF_FFFC;
                mem_wdata = $urandom;
            end
            ram_rdy   = ($urandom % 3) == 0;
            ram_rdata = $urandom;
        end
        if_req = 1'b0; mem_req = 1'b0; flush_IF = 1'b0; ram_rdy = 1'b0;
        tick(3);
        check("rnd_if_progress", n_ifv > ifv0, 1);
        check("rnd_mem_progress", n_md > md0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
